// File: rtl/lut_sweep_pkg.sv
// ----------------------------------------------------------------------------
// lut_sweep_pkg
// Shared definitions for the LUT truth-table sweeper: FSM state encoding and
// the default geometry of the neuron LUT under sweep.
// ----------------------------------------------------------------------------
package lut_sweep_pkg;

    localparam int DEF_IN_BITS  = 8;
    localparam int DEF_OUT_BITS = 1;
    localparam int DEF_WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        EMIT  = 2'd2,
        FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/lut_truth_sweeper_if.sv
// ----------------------------------------------------------------------------
// lut_truth_sweeper_if
// Valid/ready stream carrying packed truth-table words out of the sweeper.
//   m_valid : word available (master -> slave)
//   m_ready : downstream accepts the word (slave -> master)
//   m_data  : packed truth-table word, WORD_W bits
//   m_last  : final word of the sweep
// ----------------------------------------------------------------------------
interface lut_truth_sweeper_if
    import lut_sweep_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/lut_sweep_delay.sv
// ----------------------------------------------------------------------------
// lut_sweep_delay
// Valid pipeline matching the latency of the LUT under sweep, so each issued
// code is captured exactly DEPTH cycles later. DEPTH = 0 is a wire.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : a code is being issued this cycle
//   valid_o    : the response to a code issued DEPTH cycles ago is present
// ----------------------------------------------------------------------------
module lut_sweep_delay #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic valid_o
);
    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk & rst_n;
            assign valid_o        = valid_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] pipe_q;
            logic [DEPTH-1:0] pipe_d;

            // Shift form works for every DEPTH >= 1, including a single stage.
            always_comb begin
                pipe_d = (pipe_q << 1) | DEPTH'(valid_i);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe_q <= '0;
                else        pipe_q <= pipe_d;
            end

            assign valid_o = pipe_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/lut_truth_sweeper.sv
// ----------------------------------------------------------------------------
// lut_truth_sweeper
// Walks every input code of a neuron LUT, captures the responses and streams
// the resulting truth table out as packed WORD_W-bit words (lowest code in
// the LSBs of word 0).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : single-cycle sweep request, honoured only in IDLE
//   busy       : sweep in progress (SWEEP or EMIT)
//   done       : one-cycle pulse at the end of the sweep
//   lut_in     : code driven to the LUT
//   lut_out    : LUT response, LUT_LATENCY cycles behind lut_in
//   m          : packed-word stream (master side)
// ----------------------------------------------------------------------------
module lut_truth_sweeper
    import lut_sweep_pkg::*;
#(
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int LUT_LATENCY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [IN_BITS-1:0]  lut_in,
    input  logic [OUT_BITS-1:0] lut_out,
    lut_truth_sweeper_if.master m
);
    localparam int CODES     = 2 ** IN_BITS;
    localparam int CPW       = WORD_W / OUT_BITS;        // codes per word
    localparam int NUM_WORDS = CODES * OUT_BITS / WORD_W;
    // One spare bit so the count of issued codes can reach CODES itself.
    localparam int CNT_W     = $clog2(CODES) + 1;

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]   cap_cnt_q,   cap_cnt_d;
    logic [CNT_W-1:0]   word_q,      word_d;
    logic [IN_BITS-1:0] lut_in_q,    lut_in_d;
    logic [WORD_W-1:0]  data_q,      data_d;

    logic             issue_en;
    logic             cap_en;
    logic             last_word;
    logic [CNT_W-1:0] word_end;   // total code count at the end of this word

    assign word_end  = (word_q + CNT_W'(1)) * CNT_W'(CPW);
    assign last_word = (word_q == CNT_W'(NUM_WORDS - 1));
    assign issue_en  = (state_q == SWEEP) && (issue_cnt_q != word_end);

    lut_sweep_delay #(
        .DEPTH (LUT_LATENCY)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (issue_en),
        .valid_o (cap_en)
    );

    // NOTE: every signal gets its hold value first, so no path through the
    // case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        word_d      = word_q;
        lut_in_d    = lut_in_q;
        data_d      = data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SWEEP;
                    issue_cnt_d = '0;
                    cap_cnt_d   = '0;
                    word_d      = '0;
                    lut_in_d    = '0;
                end
            end

            SWEEP: begin
                if (issue_en) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                    // The last code of a word stays on lut_in through EMIT.
                    if ((issue_cnt_q + CNT_W'(1)) != word_end)
                        lut_in_d = lut_in_q + IN_BITS'(1);
                end
                if (cap_en) begin
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                    // Shift in from the top: after CPW captures the first
                    // response sits in the LSBs.
                    data_d = (data_q >> OUT_BITS) |
                             (WORD_W'(lut_out) << (WORD_W - OUT_BITS));
                    if ((cap_cnt_q + CNT_W'(1)) == word_end)
                        state_d = EMIT;
                end
            end

            EMIT: begin
                if (m.m_ready) begin
                    if (last_word) begin
                        state_d = FIN;
                    end else begin
                        state_d  = SWEEP;
                        word_d   = word_q + CNT_W'(1);
                        lut_in_d = lut_in_q + IN_BITS'(1);
                    end
                end
            end

            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values; data_q is reset too so m_data reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            word_q      <= '0;
            lut_in_q    <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            word_q      <= word_d;
            lut_in_q    <= lut_in_d;
            data_q      <= data_d;
        end
    end

    assign busy      = (state_q == SWEEP) || (state_q == EMIT);
    assign done      = (state_q == FIN);
    assign lut_in    = lut_in_q;
    assign m.m_valid = (state_q == EMIT);
    assign m.m_last  = (state_q == EMIT) && last_word;
    assign m.m_data  = data_q;
endmodule

// File: tb/tb_lut_truth_sweeper.sv
module tb_lut_truth_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0: LUT_LATENCY = 0, DUT 1: LUT_LATENCY = 2 -------
    logic       start0, start2, ready0, ready2;
    logic       busy0, busy2, done0, done2;
    logic [7:0] lut_in0, lut_in2;
    logic       lut_out0, lut_out2;
    bit         rnd_ready [2];

    lut_truth_sweeper_if #(.WORD_W(32)) bus0 ();
    lut_truth_sweeper_if #(.WORD_W(32)) bus2 ();
    assign bus0.m_ready = ready0;
    assign bus2.m_ready = ready2;

    lut_truth_sweeper #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32), .LUT_LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .lut_in(lut_in0), .lut_out(lut_out0), .m(bus0));

    lut_truth_sweeper #(.IN_BITS(8), .OUT_BITS(1), .WORD_W(32), .LUT_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .lut_in(lut_in2), .lut_out(lut_out2), .m(bus2));

    // ---------------- Neuron LUT model -------------------------------------
    // mode 0: all ones, 1: code bit 0, 2: code bit 7, 3: random neuron table
    int   mode_a [2];
    logic rand_tbl [256];

    function automatic logic lut_f(input int mode, input int code);
        case (mode)
            0:       return 1'b1;
            1:       return code[0];
            2:       return code[7];
            default: return rand_tbl[code];
        endcase
    endfunction

    function automatic logic [31:0] exp_word(input int mode, input int j);
        logic [31:0] w;
        for (int k = 0; k < 32; k++) w[k] = lut_f(mode, j * 32 + k);
        return w;
    endfunction

    assign lut_out0 = lut_f(mode_a[0], int'(lut_in0));

    logic p1, p2;   // two-stage LUT for dut2
    always @(posedge clk) begin
        p1 <= lut_f(mode_a[1], int'(lut_in2));
        p2 <= p1;
    end
    assign lut_out2 = p2;

    // ---------------- Checking ---------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int          widx      [2];
    int          done_cnt  [2];
    int          done_cyc  [2];
    int          words_cnt [2];
    logic [31:0] cap_w     [2][8];
    logic        pv [2], pr [2], pl [2];
    logic [31:0] pd [2];

    task automatic cmp_step(input int id, input logic valid, input logic ready,
                            input logic [31:0] data, input logic last,
                            input logic done, input logic busy, input logic [7:0] lin);
        if (!rst_n) begin
            check($sformatf("rst_ctrl_%0d", id), {28'd0, busy, done, valid, last}, 32'd0);
            check($sformatf("rst_data_%0d", id), data, 32'd0);
            check($sformatf("rst_lut_in_%0d", id), {24'd0, lin}, 32'd0);
            widx[id] = 0;
            pv[id]   = 1'b0;
            return;
        end
        check($sformatf("busy_done_excl_%0d", id), {31'd0, busy & done}, 32'd0);
        if (valid) begin
            if (widx[id] >= 8) begin
                check($sformatf("extra_word_%0d", id), {31'd0, valid}, 32'd0);
            end else begin
                check($sformatf("word_data_%0d_w%0d", id, widx[id]), data,
                      exp_word(mode_a[id], widx[id]));
                check($sformatf("word_last_%0d_w%0d", id, widx[id]), {31'd0, last},
                      {31'd0, widx[id] == 7});
                cap_w[id][widx[id]] = data;
            end
            if (pv[id] && !pr[id]) begin
                check($sformatf("stall_data_%0d", id), data, pd[id]);
                check($sformatf("stall_last_%0d", id), {31'd0, last}, {31'd0, pl[id]});
            end
            if (ready) begin
                widx[id]++;
                words_cnt[id]++;
            end
        end
        if (done) begin
            check($sformatf("done_words_%0d", id), widx[id], 8);
            done_cnt[id]++;
            done_cyc[id] = cyc;
            widx[id]     = 0;
        end
        pv[id] = valid;
        pr[id] = ready;
        pd[id] = data;
        pl[id] = last;
    endtask

    always @(negedge clk) begin
        cmp_step(0, bus0.m_valid, ready0, bus0.m_data, bus0.m_last, done0, busy0, lut_in0);
        cmp_step(1, bus2.m_valid, ready2, bus2.m_data, bus2.m_last, done2, busy2, lut_in2);
    end

    // Ready generator: 50% random when enabled, otherwise held high.
    initial forever begin
        @(posedge clk);
        #1;
        ready0 = rnd_ready[0] ? 1'($urandom_range(0, 1)) : 1'b1;
        ready2 = rnd_ready[1] ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- Stimulus ---------------------------------------------
    int start_cyc;

    task automatic pulse_start(input int id);
        @(posedge clk);
        #1;
        if (id == 0) start0 = 1'b1; else start2 = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int d0);
        bit got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt[id] != d0) got = 1'b1;
        end
        check($sformatf("done_seen_%0d", id), {31'd0, got}, 32'd1);
    endtask

    task automatic run_sweep(input int id, input int mode, input bit rnd, input bit chk_lat);
        int d0;
        int w0;
        mode_a[id]    = mode;
        rnd_ready[id] = rnd;
        d0 = done_cnt[id];
        w0 = words_cnt[id];
        pulse_start(id);
        wait_done(id, d0);
        if (chk_lat) check("latency_265", done_cyc[id] - start_cyc, 265);
        check($sformatf("sweep_words_%0d", id), words_cnt[id] - w0, 8);
        rnd_ready[id] = 1'b0;
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [255:0] tbl_bits;
        int           d0, w0;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start2 = 1'b0;
        ready0 = 1'b1;
        ready2 = 1'b1;
        rnd_ready[0] = 1'b0;
        rnd_ready[1] = 1'b0;
        mode_a[0] = 0;
        mode_a[1] = 0;
        for (int i = 0; i < 256; i++) rand_tbl[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 256; i++) tbl_bits[i] = rand_tbl[i];

        // Hand-computed values pinning the model
        check("pin_ones_w7", exp_word(0, 7), 32'hFFFF_FFFF);
        check("pin_bit0_w0", exp_word(1, 0), 32'hAAAA_AAAA);
        check("pin_bit7_w3", exp_word(2, 3), 32'h0000_0000);
        check("pin_bit7_w4", exp_word(2, 4), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {28'd0, busy0, done0, bus0.m_valid, bus0.m_last}, 32'd0);
        check("idle_lut_in", {24'd0, lut_in0}, 32'd0);

        // All-ones LUT with exact latency
        run_sweep(0, 0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) check($sformatf("ones_w%0d", j), cap_w[0][j], 32'hFFFF_FFFF);

        // lut_in[0] and lut_in[7] models
        run_sweep(0, 1, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) check($sformatf("bit0_w%0d", j), cap_w[0][j], 32'hAAAA_AAAA);
        run_sweep(0, 2, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++)
            check($sformatf("bit7_w%0d", j), cap_w[0][j], (j < 4) ? 32'h0 : 32'hFFFF_FFFF);

        // Generated neuron with random back-pressure
        run_sweep(0, 3, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("rand_w%0d", j), cap_w[0][j], tbl_bits[j*32 +: 32]);

        // LUT_LATENCY = 2
        run_sweep(1, 1, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("lat2_bit0_w%0d", j), cap_w[1][j], 32'hAAAA_AAAA);
        run_sweep(1, 3, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("lat2_rand_w%0d", j), cap_w[1][j], tbl_bits[j*32 +: 32]);

        // Reset during word 3 of SWEEP
        mode_a[0] = 3;
        d0 = done_cnt[0];
        pulse_start(0);
        wait_cycle(start_cyc + 110);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", {28'd0, busy0, done0, bus0.m_valid, bus0.m_last}, 32'd0);
        check("async_rst_data", bus0.m_data, 32'd0);
        check("async_rst_lut_in", {24'd0, lut_in0}, 32'd0);
        check("rst_mid_words", words_cnt[0] % 8, 3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        w0 = words_cnt[0];
        repeat (300) @(posedge clk);
        #1;
        check("post_rst_no_words", words_cnt[0] - w0, 0);
        check("post_rst_no_done", done_cnt[0] - d0, 0);
        check("post_rst_idle", {31'd0, busy0}, 32'd0);

        // Clean sweep after reset
        run_sweep(0, 3, 1'b1, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("post_rst_w%0d", j), cap_w[0][j], tbl_bits[j*32 +: 32]);

        // start while busy and in the FIN cycle is ignored
        mode_a[0] = 1;
        d0 = done_cnt[0];
        w0 = words_cnt[0];
        pulse_start(0);
        wait_cycle(start_cyc + 100);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_cycle(start_cyc + 265);
        check("fin_cycle_done", {31'd0, done0}, 32'd1);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        check("ignored_start_dones", done_cnt[0] - d0, 1);
        check("ignored_start_words", words_cnt[0] - w0, 8);
        check("ignored_start_idle", {31'd0, busy0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lut_truth_sweeper.md
LUT_TRUTH_SWEEPER -- requirements
Module: lut_truth_sweeper

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- IN_BITS, 8, input width of the neuron LUT under sweep.
- OUT_BITS, 1, output width of the neuron LUT.
- WORD_W, 32, width of each packed output word; SHALL be a multiple of OUT_BITS and SHALL divide 2^IN_BITS*OUT_BITS.
- LUT_LATENCY, 0, number of register stages between lut_in and lut_out; legal range 0..3.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle request to begin a sweep.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the sweep completes.
- lut_in, out, IN_BITS, code driven to the neuron LUT.
- lut_out, in, OUT_BITS, LUT response to lut_in, delayed by LUT_LATENCY cycles.
- m_valid, out, 1, packed word available.
- m_ready, in, 1, downstream accepts the word.
- m_data, out, WORD_W, packed truth-table word.
- m_last, out, 1, marks the final word of the sweep.

Function
REQ-003 The FSM SHALL have states IDLE, SWEEP, EMIT and FIN.
REQ-004 In IDLE, start=1 SHALL clear the issue and capture counters and the word index, and move the FSM to SWEEP; busy SHALL rise in the next cycle.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 In SWEEP, the block SHALL issue one code per cycle on lut_in, incrementing by 1, until WORD_W/OUT_BITS codes of the current word have been issued.
REQ-007 Capture of each response SHALL occur exactly LUT_LATENCY cycles after its code was issued. An internal valid pipeline of depth LUT_LATENCY SHALL track the issued codes.
REQ-008 Packing order SHALL be: bits [k*OUT_BITS +: OUT_BITS] of word j hold the response to code j*(WORD_W/OUT_BITS)+k (LSB = lowest code).
REQ-009 When the last code of a word has been captured, the FSM SHALL move to EMIT. No codes SHALL be issued in EMIT, and lut_in SHALL hold its last value.
REQ-010 In EMIT, m_valid=1 SHALL hold, and m_data and m_last SHALL be stable until m_ready=1.
- On a handshake with words remaining, the FSM SHALL return to SWEEP.
- On a handshake with the final word, the FSM SHALL go to FIN.
REQ-011 m_last SHALL be 1 only on word index (2^IN_BITS*OUT_BITS/WORD_W)-1.
REQ-012 FIN SHALL assert done for exactly one cycle, deassert busy, and return to IDLE. A start in that same cycle SHALL be ignored.
REQ-013 With LUT_LATENCY=0, a full sweep SHALL take exactly 2^IN_BITS + (number of words) + 1 cycles from the start cycle to the done pulse, given m_ready held at 1.
REQ-014 Counters SHALL be sized $clog2(2^IN_BITS)+1 bits so the final increment does not wrap to 0 before the sweep-end comparison.

Reset
REQ-015 Asserting rst_n=0 SHALL immediately set FSM=IDLE, busy=0, done=0, m_valid=0, m_last=0, m_data=0, lut_in=0, and clear all counters and pipeline valids. This SHALL apply in any state, including mid-SWEEP and mid-EMIT.
REQ-016 After rst_n rises, the block SHALL remain in IDLE until a new start; no partial word SHALL be emitted.

Structure
REQ-017 The state enumeration and default IN_BITS/OUT_BITS/WORD_W constants SHALL reside in the shared package lut_sweep_pkg.
REQ-018 The latency-matching valid pipeline SHALL be one sub-module, lut_sweep_delay (parameter DEPTH; DEPTH=0 is a pass-through).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- LUT model lut_out=1 for all codes, m_ready=1 -> 8 words of 0xFFFFFFFF, m_last on word 7, done 265 cycles after start.
- LUT model lut_out=lut_in[0] -> 8 words of 0xAAAAAAAA; with lut_out=lut_in[7] instead -> words 0-3 = 0x00000000 and words 4-7 = 0xFFFFFFFF.
- Random m_ready (50%) with a generated-neuron model -> m_data/m_last stable while stalled; the packed 256 bits match the model bit-exactly.
- LUT_LATENCY=2 with the lut_in[0] model -> still 0xAAAAAAAA; no off-by-two shift.
- rst_n pulsed low during word 3 of SWEEP -> all outputs 0 immediately, no further m_valid; a new start completes a clean 8-word sweep.
- start pulsed while busy and during the FIN cycle -> ignored; exactly one done and 8 words per accepted start.
